tablero_juego: RTL and testbench
================================

# tablero_juego

Parametrised N×N tic-tac-toe game controller for the VGA game top. Owns board state, cursor, turn alternation, occupied-cell rejection, win/draw detection and restart. Consumes the two raw push-button levels and exports the packed board for the per-cell sprite muxes. Replaces the fixed nine-register, two-counter arrangement with one sequential block.

## Interface
- N, default 3, board side; legal range 3..8, cells = N*N.
- clk  in  1  system clock.
- boton_rst  in  1  reset, asynchronous, active-high.
- boton_Cuenta_Casilla  in  1  raw level, already synchronised; rising edge advances the cursor.
- boton_Seleccionador  in  1  raw level, already synchronised; rising edge places a mark, or restarts after game end.
- cursor  out  $clog2(N*N)  selected cell index, row-major: row = idx/N, col = idx%N.
- casillas  out  2*N*N  packed board; cell i at [2i+1:2i]: 00 empty, 01 player 1, 10 player 2.
- turno  out  1  player to move: 0 = player 1, 1 = player 2.
- gano  out  2  00 none, 01 player 1 won, 10 player 2 won, 11 draw.
- fin  out  1  high while in FIN.
- escrito  out  1  one-cycle strobe on the cycle a mark is written.
- rechazo  out  1  one-cycle strobe when a place press hits an occupied cell.

## Operation
- Edge detection: per button, a one-cycle pulse = level & ~level_q. level_q resets to 1, so a button held through reset release produces no pulse.
- FSM states:
  - JUGANDO
    - Advance pulse: cursor = (cursor+1) mod N*N; wrap from N*N-1 to 0.
    - Place pulse on an empty cell: write code {turno, ~turno} into the cell, increment jugadas, pulse escrito, go to EVALUAR.
    - Place pulse on an occupied cell: board unchanged, pulse rechazo, stay in JUGANDO.
  - EVALUAR (exactly 1 cycle)
    - Check every row, every column and both diagonals for N equal marks of the current turno's player.
    - Win: gano = 01 or 10, go to FIN, turno unchanged.
    - Otherwise, if jugadas == N*N: gano = 11, go to FIN.
    - Otherwise: toggle turno, return to JUGANDO.
  - FIN
    - Advance pulses are ignored; the cursor is frozen.
    - A place pulse clears all cells, jugadas, gano and cursor to 0, sets turno to 0 and returns to JUGANDO. No escrito strobe.
- Simultaneous advance and place pulses in JUGANDO: the place is applied at the old cursor; the cursor does not move that cycle.
- Pulses arriving in EVALUAR are dropped.
- jugadas width is $clog2(N*N+1); it never exceeds N*N.

## Timing
- Reset values: casillas 0, cursor 0, turno 0, gano 00, fin 0, escrito 0, rechazo 0, jugadas 0, state JUGANDO.
- Button first sampled high at edge E0: pulse is asserted in cycle E0→E1.
  - Advance: cursor updates at E1.
  - Place: cell write, escrito = 1 and state EVALUAR all take effect at E1.
  - Result: turno/gano/fin update at E2.
- Press-to-result latency is 2 edges. The minimum spacing between two accepted places is 2 cycles.
- rechazo is registered, asserted in the cycle after the rejected pulse.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset asserted mid-operation, including during EVALUAR, immediately returns every register to its reset value.

## Structure
- juego_pkg holds:
  - typedef enum estado_t {JUGANDO, EVALUAR, FIN}.
  - Cell constants VACIA = 2'b00, J1 = 2'b01, J2 = 2'b10.
  - gano constants NADIE, GANA1, GANA2, EMPATE.
- Win check is a combinational function over casillas, parametrised by N, using loop generation.
- Sub-module detector_flanco (clk, boton_rst, level, pulse), instantiated once per button.

## Test plan
- Reset, N=3:
  - 5 advance presses → cursor = 5.
  - 9 more presses → cursor = 5 again, via wrap 8→0.
- Player 1 at cells 0, 1, 2 and player 2 at cells 3, 4:
  - After the 5th place: gano = 01, fin = 1, turno = 0.
  - casillas[5:0] = 01_01_01.
- Place on an occupied cell:
  - rechazo pulses for 1 cycle; casillas, turno and jugadas are unchanged.
  - The next valid place still writes the same player's mark.
- Full N=3 board with no line (order 0, 1, 2, 4, 3, 5, 7, 6, 8):
  - gano = 11 two cycles after the 9th press.
  - A place in FIN clears casillas to 0 and sets turno to 0.
- N=4:
  - Player 2 fills the anti-diagonal (cells 3, 6, 9, 12) → gano = 10.
  - Advance and place pulses in the same cycle write at the old cursor and leave the cursor unmoved.
- Reset asserted while in EVALUAR, and a button held high across reset release:
  - All outputs return to their reset values.
  - No pulse, cursor or write occurs until the button is released and pressed again.

Source files
------------

// File: rtl/juego_pkg.sv
// rtl/juego_pkg.sv - shared states and cell/result encodings for the tic-tac-toe controller
package juego_pkg;

   typedef enum logic [1:0] {JUGANDO, EVALUAR, FIN} estado_t;

   localparam logic [1:0] VACIA  = 2'b00;
   localparam logic [1:0] J1     = 2'b01;
   localparam logic [1:0] J2     = 2'b10;

   localparam logic [1:0] NADIE  = 2'b00;
   localparam logic [1:0] GANA1  = 2'b01;
   localparam logic [1:0] GANA2  = 2'b10;
   localparam logic [1:0] EMPATE = 2'b11;

endpackage

// File: rtl/detector_flanco.sv
// rtl/detector_flanco.sv - registered rising-edge pulse from a synchronised button level
module detector_flanco (
   input  logic clk,
   input  logic boton_rst,
   input  logic level,
   output logic pulse
);

   logic level_q;

   // level_q resets high so a button held through reset release gives no pulse
   always_ff @(posedge clk or posedge boton_rst) begin
      if (boton_rst) begin
         level_q <= 1'b1;
         pulse   <= 1'b0;
      end else begin
         level_q <= level;
         pulse   <= level & ~level_q;
      end
   end

endmodule

// File: rtl/tablero_juego.sv
// rtl/tablero_juego.sv - N x N tic-tac-toe controller: board, cursor, turns, win/draw, restart
module tablero_juego
   import juego_pkg::*;
#(
   parameter int N = 3
) (
   input  logic                      clk,
   input  logic                      boton_rst,
   input  logic                      boton_Cuenta_Casilla,
   input  logic                      boton_Seleccionador,
   output logic [$clog2(N*N)-1:0]    cursor,
   output logic [2*N*N-1:0]          casillas,
   output logic                      turno,
   output logic [1:0]                gano,
   output logic                      fin,
   output logic                      escrito,
   output logic                      rechazo
);

   localparam int CELDAS = N * N;
   localparam int CW     = $clog2(CELDAS);
   localparam int JW     = $clog2(CELDAS + 1);
   localparam logic [CW-1:0] ULTIMA = CW'(CELDAS - 1);
   localparam logic [JW-1:0] TOTAL  = JW'(CELDAS);

   logic pulso_avz, pulso_sel;

   detector_flanco u_flanco_avz (
      .clk       (clk),
      .boton_rst (boton_rst),
      .level     (boton_Cuenta_Casilla),
      .pulse     (pulso_avz)
   );

   detector_flanco u_flanco_sel (
      .clk       (clk),
      .boton_rst (boton_rst),
      .level     (boton_Seleccionador),
      .pulse     (pulso_sel)
   );

   // True when every cell of some row, column or diagonal holds marca
   function automatic logic hay_linea(input logic [2*CELDAS-1:0] tab, input logic [1:0] marca);
      logic resultado, fila, columna, diag, anti;
      resultado = 1'b0;
      diag      = 1'b1;
      anti      = 1'b1;
      for (int r = 0; r < N; r++) begin
         fila    = 1'b1;
         columna = 1'b1;
         for (int c = 0; c < N; c++) begin
            if (tab[2*(r*N+c) +: 2] != marca) fila = 1'b0;
            if (tab[2*(c*N+r) +: 2] != marca) columna = 1'b0;
         end
         resultado = resultado | fila | columna;
         if (tab[2*(r*N+r) +: 2] != marca) diag = 1'b0;
         if (tab[2*(r*N+N-1-r) +: 2] != marca) anti = 1'b0;
      end
      return resultado | diag | anti;
   endfunction

   estado_t           estado, estado_d;
   logic [2*CELDAS-1:0] casillas_d;
   logic [CW-1:0]     cursor_d;
   logic [JW-1:0]     jugadas, jugadas_d;
   logic              turno_d, fin_d, escrito_d, rechazo_d;
   logic [1:0]        gano_d;
   logic [1:0]        marca;
   logic [CW:0]       base;

   // State and every output register; reset clears the whole game at once
   always_ff @(posedge clk or posedge boton_rst) begin
      if (boton_rst) begin
         estado   <= JUGANDO;
         casillas <= '0;
         cursor   <= '0;
         jugadas  <= '0;
         turno    <= 1'b0;
         gano     <= NADIE;
         fin      <= 1'b0;
         escrito  <= 1'b0;
         rechazo  <= 1'b0;
      end else begin
         estado   <= estado_d;
         casillas <= casillas_d;
         cursor   <= cursor_d;
         jugadas  <= jugadas_d;
         turno    <= turno_d;
         gano     <= gano_d;
         fin      <= fin_d;
         escrito  <= escrito_d;
         rechazo  <= rechazo_d;
      end
   end

   // Next game state: placing has priority over advancing, EVALUAR drops all pulses
   always_comb begin
      estado_d   = estado;
      casillas_d = casillas;
      cursor_d   = cursor;
      jugadas_d  = jugadas;
      turno_d    = turno;
      gano_d     = gano;
      escrito_d  = 1'b0;
      rechazo_d  = 1'b0;
      marca      = turno ? J2 : J1;
      base       = {cursor, 1'b0};
      case (estado)
         JUGANDO: begin
            if (pulso_sel) begin
               if (casillas[base +: 2] != VACIA) begin
                  rechazo_d = 1'b1;
               end else begin
                  casillas_d[base +: 2] = marca;
                  jugadas_d = jugadas + 1'b1;
                  escrito_d = 1'b1;
                  estado_d  = EVALUAR;
               end
            end else if (pulso_avz) begin
               cursor_d = (cursor == ULTIMA) ? '0 : cursor + 1'b1;
            end
         end
         EVALUAR: begin
            if (hay_linea(casillas, marca)) begin
               gano_d   = turno ? GANA2 : GANA1;
               estado_d = FIN;
            end else if (jugadas == TOTAL) begin
               gano_d   = EMPATE;
               estado_d = FIN;
            end else begin
               turno_d  = ~turno;
               estado_d = JUGANDO;
            end
         end
         FIN: begin
            if (pulso_sel) begin
               casillas_d = '0;
               jugadas_d  = '0;
               gano_d     = NADIE;
               cursor_d   = '0;
               turno_d    = 1'b0;
               estado_d   = JUGANDO;
            end
         end
         default: estado_d = JUGANDO;
      endcase
      fin_d = (estado_d == FIN);
   end

endmodule

// File: tb/tb_tablero_juego.sv
// tb/tb_tablero_juego.sv - bench for tablero_juego with N=3 and N=4 instances against a game-level model
module tb_tablero_juego;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] adv, sel;

   logic [3:0]  cur3, cur4;
   logic [17:0] cas3;
   logic [31:0] cas4;
   logic        tur3, tur4, fin3, fin4, esc3, esc4, rec3, rec4;
   logic [1:0]  gan3, gan4;

   always #5 clk = ~clk;

   tablero_juego #(.N(3)) dut3 (
      .clk(clk), .boton_rst(rst),
      .boton_Cuenta_Casilla(adv[0]), .boton_Seleccionador(sel[0]),
      .cursor(cur3), .casillas(cas3), .turno(tur3), .gano(gan3),
      .fin(fin3), .escrito(esc3), .rechazo(rec3)
   );

   tablero_juego #(.N(4)) dut4 (
      .clk(clk), .boton_rst(rst),
      .boton_Cuenta_Casilla(adv[1]), .boton_Seleccionador(sel[1]),
      .cursor(cur4), .casillas(cas4), .turno(tur4), .gano(gan4),
      .fin(fin4), .escrito(esc4), .rechazo(rec4)
   );

   // ---------------- game-level model ----------------
   int m_n[2];
   int m_board[2][16];
   int m_cur[2], m_turno[2], m_gano[2], m_jug[2];
   bit m_fin[2], m_eval[2], m_esc[2], m_rec[2];
   bit p_adv[2], p_sel[2], q_adv[2], q_sel[2];

   int vectors = 0;
   int errors  = 0;
   bit checking = 0;

   function automatic void m_clear(int k);
      for (int i = 0; i < 16; i++) m_board[k][i] = 0;
      m_cur[k] = 0; m_turno[k] = 0; m_gano[k] = 0; m_jug[k] = 0;
      m_fin[k] = 0; m_eval[k] = 0;
   endfunction

   function automatic void m_reset(int k);
      m_clear(k);
      m_esc[k] = 0; m_rec[k] = 0;
      p_adv[k] = 0; p_sel[k] = 0; q_adv[k] = 1; q_sel[k] = 1;
   endfunction

   function automatic bit linea(int k, int p);
      int n, cf, cc, cd, ca;
      n = m_n[k]; cd = 0; ca = 0;
      for (int r = 0; r < n; r++) begin
         cf = 0; cc = 0;
         for (int c = 0; c < n; c++) begin
            if (m_board[k][r*n+c] == p) cf++;
            if (m_board[k][c*n+r] == p) cc++;
         end
         if (cf == n || cc == n) return 1;
         if (m_board[k][r*n+r] == p) cd++;
         if (m_board[k][r*n+(n-1-r)] == p) ca++;
      end
      return (cd == n) || (ca == n);
   endfunction

   function automatic void m_step(int k);
      int n2, p;
      n2 = m_n[k] * m_n[k];
      m_esc[k] = 0; m_rec[k] = 0;
      if (m_eval[k]) begin
         m_eval[k] = 0;
         p = m_turno[k] + 1;
         if (linea(k, p)) begin m_gano[k] = p; m_fin[k] = 1; end
         else if (m_jug[k] == n2) begin m_gano[k] = 3; m_fin[k] = 1; end
         else m_turno[k] = 1 - m_turno[k];
      end else if (m_fin[k]) begin
         if (p_sel[k]) m_clear(k);
      end else if (p_sel[k]) begin
         if (m_board[k][m_cur[k]] == 0) begin
            m_board[k][m_cur[k]] = m_turno[k] + 1;
            m_jug[k]++;
            m_esc[k] = 1;
            m_eval[k] = 1;
         end else m_rec[k] = 1;
      end else if (p_adv[k]) begin
         m_cur[k] = (m_cur[k] + 1) % n2;
      end
      p_adv[k] = adv[k] && !q_adv[k]; q_adv[k] = adv[k];
      p_sel[k] = sel[k] && !q_sel[k]; q_sel[k] = sel[k];
   endfunction

   function automatic logic [63:0] pack(int k);
      logic [63:0] v;
      v = '0;
      for (int i = 0; i < m_n[k]*m_n[k]; i++) v[2*i +: 2] = 2'(m_board[k][i]);
      return v;
   endfunction

   always @(posedge clk or posedge rst) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) m_reset(k);
         else     m_step(k);
      end
   end

   // ---------------- checking ----------------
   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (checking) begin
            chk("n3.cursor",   cur3, m_cur[0]);
            chk("n3.casillas", cas3, pack(0));
            chk("n3.turno",    tur3, m_turno[0]);
            chk("n3.gano",     gan3, m_gano[0]);
            chk("n3.fin",      fin3, m_fin[0]);
            chk("n3.escrito",  esc3, m_esc[0]);
            chk("n3.rechazo",  rec3, m_rec[0]);
            chk("n4.cursor",   cur4, m_cur[1]);
            chk("n4.casillas", cas4, pack(1));
            chk("n4.turno",    tur4, m_turno[1]);
            chk("n4.gano",     gan4, m_gano[1]);
            chk("n4.fin",      fin4, m_fin[1]);
            chk("n4.escrito",  esc4, m_esc[1]);
            chk("n4.rechazo",  rec4, m_rec[1]);
         end
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic [63:0] dut_cur(int k);
      return (k == 1) ? 64'(cur4) : 64'(cur3);
   endfunction

   task automatic tick(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press_adv(int k);
      @(negedge clk) adv[k] = 1'b1;
      @(negedge clk) adv[k] = 1'b0;
   endtask

   task automatic press_sel(int k);
      @(negedge clk) sel[k] = 1'b1;
      @(negedge clk) sel[k] = 1'b0;
      tick(2);
   endtask

   task automatic goto(int k, int c);
      for (int i = 0; i < 16 && dut_cur(k) != 64'(c); i++) begin
         press_adv(k);
         tick(1);
      end
      chk("goto", dut_cur(k), 64'(c));
   endtask

   task automatic place(int k, int c);
      goto(k, c);
      press_sel(k);
   endtask

   initial begin
      int orden[9];
      orden = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
      m_n[0] = 3; m_n[1] = 4;
      adv = '0; sel = '0; rst = 1'b0;
      #1 rst = 1'b1;
      checking = 1;
      tick(3);
      rst = 1'b0;
      tick(1);
      chk("rst_cursor", cur3, 0);
      chk("rst_casillas", cas3, 0);
      chk("rst_turno", tur3, 0);
      chk("rst_gano", gan3, 0);
      chk("rst_fin", fin3, 0);

      // cursor advance and wrap
      repeat (5) press_adv(0);
      tick(1);
      chk("adv5", cur3, 5);
      repeat (9) press_adv(0);
      tick(1);
      chk("wrap", cur3, 5);

      // player 1 wins the top row
      place(0, 0); place(0, 3); place(0, 1); place(0, 4); place(0, 2);
      chk("win_gano", gan3, 2'b01);
      chk("win_fin", fin3, 1);
      chk("win_turno", tur3, 0);
      chk("win_row", cas3[5:0], 6'b010101);
      chk("win_board", cas3, 18'h00295);
      press_adv(0); tick(1);
      chk("fin_frozen", cur3, 2);
      press_sel(0);
      chk("restart_cas", cas3, 0);
      chk("restart_turno", tur3, 0);
      chk("restart_cursor", cur3, 0);

      // occupied-cell rejection
      place(0, 0);
      chk("occ_turno1", tur3, 1);
      @(negedge clk) sel[0] = 1'b1;
      @(negedge clk) sel[0] = 1'b0;
      @(negedge clk);
      chk("rechazo_on", rec3, 1);
      chk("rechazo_cas", cas3, 18'h00001);
      chk("rechazo_turno", tur3, 1);
      @(negedge clk);
      chk("rechazo_off", rec3, 0);
      place(0, 1);
      chk("after_reject", cas3, 18'h00009);
      @(negedge clk) rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);

      // draw on a full N=3 board
      for (int i = 0; i < 9; i++) place(0, orden[i]);
      chk("draw_gano", gan3, 2'b11);
      chk("draw_fin", fin3, 1);
      chk("draw_board", cas3, 18'h16A59);
      press_sel(0);
      chk("draw_clear", cas3, 0);
      chk("draw_turno", tur3, 0);
      chk("draw_gano0", gan3, 0);

      // N=4: player 2 takes the anti-diagonal
      place(1, 0); place(1, 3); place(1, 1); place(1, 6);
      place(1, 2); place(1, 9); place(1, 4); place(1, 12);
      chk("n4_gano", gan4, 2'b10);
      chk("n4_turno", tur4, 1);
      chk("n4_fin", fin4, 1);
      chk("n4_board", cas4, 32'h02082195);
      press_sel(1);
      goto(1, 5);
      @(negedge clk) begin adv[1] = 1'b1; sel[1] = 1'b1; end
      @(negedge clk) begin adv[1] = 1'b0; sel[1] = 1'b0; end
      tick(2);
      chk("both_cursor", cur4, 5);
      chk("both_board", cas4, 32'h00000400);

      // reset during EVALUAR with buttons held across release
      @(negedge clk) sel[0] = 1'b1;
      @(negedge clk) sel[0] = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1; adv[0] = 1'b1; sel[0] = 1'b1;
      @(negedge clk);
      chk("evrst_cas", cas3, 0);
      chk("evrst_esc", esc3, 0);
      @(negedge clk) rst = 1'b0;
      tick(3);
      chk("held_cursor", cur3, 0);
      chk("held_cas", cas3, 0);
      adv[0] = 1'b0; sel[0] = 1'b0;
      tick(1);
      press_adv(0);
      tick(1);
      chk("repress_cursor", cur3, 1);
      tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
